// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared modes, width helpers and pipeline latency for the Sobel edge core
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_BINARY  = 2'd0,
    MODE_MAG     = 2'd1,
    MODE_MAG_THR = 2'd2,
    MODE_RSVD    = 2'd3
  } sobel_mode_e;

  localparam int LATENCY = 4;

  // Partial-sum and gradient widths derived from the luma width.
  function automatic int sum_w(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int g_w(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/sobel_win3x3.sv
// rtl/sobel_win3x3.sv - two line buffers, col/row counters and the 3x3 luma window (stage S0)
module sobel_win3x3
  import sobel_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_vsync,
  input  logic              pix_de,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] win [3][3],
  output logic              win_valid
);

  localparam int CW = $clog2(IMG_W + 1);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];
  logic [CW-1:0]     col;
  logic [1:0]        row;
  logic              vs_d;
  logic              de_d;
  logic              in_line;
  logic [AW-1:0]     addr;

  assign in_line = (col < CW'(IMG_W));
  assign addr    = col[AW-1:0];

  // lb1 holds the previous line, lb2 the one before; read-before-write at col.
  always_ff @(posedge clk) begin
    if (pix_de && in_line) begin
      lb1[addr] <= pix_data;
      lb2[addr] <= lb1[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col       <= '0;
      row       <= '0;
      vs_d      <= 1'b0;
      de_d      <= 1'b0;
      win_valid <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      vs_d <= pix_vsync;
      de_d <= pix_de;

      if (pix_vsync && !vs_d)
        row <= '0;
      else if (de_d && !pix_de && row != 2'd2)
        row <= row + 2'd1;

      if (!pix_de)
        col <= '0;
      else if (in_line)
        col <= col + CW'(1);

      win_valid <= pix_de && in_line && (col >= CW'(2)) && (row == 2'd2);

      if (pix_de) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= in_line ? lb2[addr] : '0;
        win[1][2] <= in_line ? lb1[addr] : '0;
        win[2][2] <= pix_data;
      end
    end
  end

endmodule

// File: rtl/sobel_edge_core.sv
// rtl/sobel_edge_core.sv - Sobel gradient pipeline S1..S3 with edge/magnitude output mux and sync delay
module sobel_edge_core
  import sobel_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 1024,
  parameter bit EDGE_POL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_vsync,
  input  logic              pix_hsync,
  input  logic              pix_de,
  input  logic [DATA_W-1:0] pix_data,
  input  logic [DATA_W+2:0] thresh,
  input  logic [1:0]        mode,
  output logic              sobel_vsync,
  output logic              sobel_hsync,
  output logic              sobel_de,
  output logic [DATA_W-1:0] sobel_data,
  output logic              sobel_edge
);

  localparam int SUM_W = sum_w(DATA_W);
  localparam int G_W   = g_w(DATA_W);
  localparam logic [G_W-1:0] MAG_MAX = G_W'((1 << DATA_W) - 1);

  logic [DATA_W-1:0]  win [3][3];
  logic               win_valid;
  logic [SUM_W-1:0]   gx1, gx3, gy1, gy3;
  logic [SUM_W-1:0]   gx, gy;
  logic               v1, v2;
  logic [LATENCY-1:0] vs_sr, hs_sr, de_sr;
  logic [G_W-1:0]     g_c;
  logic [DATA_W-1:0]  mag_c;
  logic [DATA_W-1:0]  data_c;
  logic               edge_c;
  logic               de_s3;

  function automatic logic [SUM_W-1:0] wsum(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] c);
    return SUM_W'(a) + {1'b0, b, 1'b0} + SUM_W'(c);
  endfunction

  sobel_win3x3 #(.DATA_W(DATA_W), .IMG_W(IMG_W)) u_win (
    .clk       (clk),
    .rst       (rst),
    .pix_vsync (pix_vsync),
    .pix_de    (pix_de),
    .pix_data  (pix_data),
    .win       (win),
    .win_valid (win_valid)
  );

  assign sobel_vsync = vs_sr[LATENCY-1];
  assign sobel_hsync = hs_sr[LATENCY-1];
  assign sobel_de    = de_sr[LATENCY-1];
  assign de_s3       = de_sr[LATENCY-2];

  always_comb begin
    g_c    = v2 ? (G_W'(gx) + G_W'(gy)) : '0;
    edge_c = de_s3 && (g_c > thresh);
    mag_c  = (g_c > MAG_MAX) ? '1 : g_c[DATA_W-1:0];
    data_c = '0;
    case (sobel_mode_e'(mode))
      MODE_MAG:     data_c = mag_c;
      MODE_MAG_THR: data_c = edge_c ? mag_c : '0;
      default:      data_c = '0;
    endcase
    if (!de_s3)
      data_c = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx1        <= '0;
      gx3        <= '0;
      gy1        <= '0;
      gy3        <= '0;
      gx         <= '0;
      gy         <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      vs_sr      <= '0;
      hs_sr      <= '0;
      de_sr      <= '0;
      sobel_data <= '0;
      sobel_edge <= ~EDGE_POL;
    end else begin
      gx1 <= wsum(win[0][0], win[1][0], win[2][0]);
      gx3 <= wsum(win[0][2], win[1][2], win[2][2]);
      gy1 <= wsum(win[0][0], win[0][1], win[0][2]);
      gy3 <= wsum(win[2][0], win[2][1], win[2][2]);
      v1  <= win_valid;

      gx <= (gx1 >= gx3) ? gx1 - gx3 : gx3 - gx1;
      gy <= (gy1 >= gy3) ? gy1 - gy3 : gy3 - gy1;
      v2 <= v1;

      vs_sr <= {vs_sr[LATENCY-2:0], pix_vsync};
      hs_sr <= {hs_sr[LATENCY-2:0], pix_hsync};
      de_sr <= {de_sr[LATENCY-2:0], pix_de};

      sobel_data <= data_c;
      sobel_edge <= edge_c ? EDGE_POL : ~EDGE_POL;
    end
  end

endmodule

// File: tb/tb_sobel_edge_core.sv
// tb/tb_sobel_edge_core.sv - randomized frames checked against a frame-level Sobel model
module tb_sobel_edge_core;
  import sobel_pkg::*;

  localparam int DATA_W   = 8;
  localparam int IMG_W    = 8;
  localparam bit EDGE_POL = 1'b0;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_vsync, pix_hsync, pix_de;
  logic [DATA_W-1:0] pix_data;
  logic [DATA_W+2:0] thresh;
  logic [1:0]        mode;
  logic              sobel_vsync, sobel_hsync, sobel_de, sobel_edge;
  logic [DATA_W-1:0] sobel_data;

  always #5 clk = ~clk;

  sobel_edge_core #(.DATA_W(DATA_W), .IMG_W(IMG_W), .EDGE_POL(EDGE_POL)) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_vsync   (pix_vsync),
    .pix_hsync   (pix_hsync),
    .pix_de      (pix_de),
    .pix_data    (pix_data),
    .thresh      (thresh),
    .mode        (mode),
    .sobel_vsync (sobel_vsync),
    .sobel_hsync (sobel_hsync),
    .sobel_de    (sobel_de),
    .sobel_data  (sobel_data),
    .sobel_edge  (sobel_edge)
  );

  typedef struct {
    bit vs;
    bit hs;
    bit de;
    int g;
  } exp_t;

  exp_t q[$];
  int   img [0:15][0:15];
  int   r_m, c_m;
  bit   vs_prev, de_prev;
  bit   rand_ctl;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sobel_g(input int r, input int c);
    int w [3] = '{1, 2, 1};
    int gx = 0;
    int gy = 0;
    for (int i = 0; i < 3; i++) begin
      gx += w[i] * (img[r-2+i][c-2] - img[r-2+i][c]);
      gy += w[i] * (img[r-2][c-2+i] - img[r][c-2+i]);
    end
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return gx + gy;
  endfunction

  task automatic compare_out(input exp_t e);
    bit edge_x;
    bit edge_lvl;
    int mag;
    int d;
    edge_x   = e.de && (e.g > int'(thresh));
    edge_lvl = edge_x ? EDGE_POL : !EDGE_POL;
    mag      = (e.g > 255) ? 255 : e.g;
    case (int'(mode))
      1:       d = mag;
      2:       d = edge_x ? mag : 0;
      default: d = 0;
    endcase
    if (!e.de) d = 0;
    check("vsync", sobel_vsync, e.vs);
    check("hsync", sobel_hsync, e.hs);
    check("de",    sobel_de,    e.de);
    check("data",  sobel_data,  d);
    check("edge",  sobel_edge,  edge_lvl);
  endtask

  task automatic tick(input bit vs, input bit hs, input bit de, input int data);
    exp_t e;
    pix_vsync = vs;
    pix_hsync = hs;
    pix_de    = de;
    pix_data  = DATA_W'(data);
    if (vs && !vs_prev)
      r_m = 0;
    else if (de_prev && !de && r_m < 15)
      r_m++;
    e.vs = vs;
    e.hs = hs;
    e.de = de;
    e.g  = 0;
    if (de) begin
      img[r_m][c_m] = data;
      if (r_m >= 2 && c_m >= 2 && c_m < IMG_W)
        e.g = sobel_g(r_m, c_m);
      if (c_m < 15) c_m++;
    end else begin
      c_m = 0;
    end
    vs_prev = vs;
    de_prev = de;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == LATENCY) begin
      e = q.pop_front();
      compare_out(e);
    end
  endtask

  function automatic int pix(input int kind, input int c);
    case (kind)
      1:       return 100;
      2:       return (c < 4) ? 0 : 255;
      3:       return c * 10;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send_line(input int n, input int kind);
    if (rand_ctl) begin
      mode   = 2'($urandom_range(0, 3));
      thresh = 11'($urandom_range(0, 700));
    end
    tick(0, 1, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    for (int c = 0; c < n; c++) begin
      if (rand_ctl && c == 5) thresh = 11'($urandom_range(0, 700));
      tick(0, 0, 1, pix(kind, c));
    end
    repeat (3) tick(0, 0, 0, 0);
  endtask

  task automatic send_frame(input int rows, input int cols, input int kind);
    repeat (2) tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    for (int r = 0; r < rows; r++) send_line(cols, kind);
    repeat (4) tick(0, 0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vsync"}, sobel_vsync, 0);
    check({tag, "_hsync"}, sobel_hsync, 0);
    check({tag, "_de"},    sobel_de,    0);
    check({tag, "_data"},  sobel_data,  0);
    check({tag, "_edge"},  sobel_edge,  !EDGE_POL);
  endtask

  task automatic model_clear();
    q.delete();
    vs_prev = 1'b0;
    de_prev = 1'b0;
    r_m     = 0;
    c_m     = 0;
  endtask

  initial begin
    rst       = 1'b1;
    pix_vsync = 1'b0;
    pix_hsync = 1'b0;
    pix_de    = 1'b0;
    pix_data  = '0;
    mode      = 2'd1;
    thresh    = '0;
    rand_ctl  = 1'b0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = 0;
    model_clear();
    #1;
    check_reset_outputs("rst_init");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    mode = 2'd1; thresh = 11'd0;    send_frame(6, 8, 1);
    mode = 2'd1; thresh = 11'd0;    send_frame(6, 8, 2);
    mode = 2'd0; thresh = 11'd1019; send_frame(6, 8, 2);
    mode = 2'd0; thresh = 11'd1020; send_frame(6, 8, 2);
    mode = 2'd2; thresh = 11'd79;   send_frame(6, 8, 3);
    mode = 2'd2; thresh = 11'd80;   send_frame(6, 8, 3);
    mode = 2'd3; thresh = 11'd100;  send_frame(6, 8, 2);
    mode = 2'd1; thresh = 11'd200;  send_frame(6, 12, 0);
    mode = 2'd0; thresh = 11'd150;  send_frame(6, 12, 0);

    rand_ctl = 1'b1;
    repeat (5) send_frame(6, 8, 0);
    rand_ctl = 1'b0;

    mode = 2'd1; thresh = 11'd500;
    repeat (2) tick(1, 0, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    repeat (3) send_line(8, 2);
    tick(0, 1, 0, 0);
    repeat (2) tick(0, 0, 0, 0);
    for (int c = 0; c < 6; c++) tick(0, 0, 1, pix(2, c));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    pix_de    = 1'b0;
    pix_hsync = 1'b0;
    pix_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    model_clear();
    send_frame(6, 8, 2);
    mode = 2'd2; thresh = 11'd1019; send_frame(6, 8, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sobel_edge_core.md
# sobel_edge_core

Parametrised Sobel edge detector that replaces the fixed 8-bit, binary-only Sobel stage in the image-process chain. It sits after the RGB→Y conversion and before the frame-buffer write path. It builds its own 3×3 window from two internal line buffers and suppresses border pixels. It outputs either a thresholded edge bit or a saturated gradient magnitude, with DE/HSYNC/VSYNC delayed to match.

## Interface
Parameters:
- DATA_W, 8: luma and magnitude width, 4..12.
- IMG_W, 1024: maximum active pixels per line; sets line-buffer depth.
- EDGE_POL, 0: level of `sobel_edge` for an edge pixel. 0 gives black edges on a white background.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  reset, asynchronous, active-high.
- pix_vsync, pix_hsync, pix_de  in  1 each  input timing from the Y stage.
- pix_data  in  DATA_W  luma sample, valid when `pix_de`=1.
- thresh  in  DATA_W+3  edge threshold, quasi-static; sampled every cycle.
- mode  in  2  output mode: 0 BINARY, 1 MAG, 2 MAG_THR, 3 reserved (behaves as 0).
- sobel_vsync, sobel_hsync, sobel_de  out  1 each  input timing delayed by 4 cycles.
- sobel_data  out  DATA_W  magnitude result. Forced to 0 in BINARY mode and when `sobel_de`=0.
- sobel_edge  out  1  edge flag. Equals EDGE_POL when an edge is present, otherwise ~EDGE_POL.

## Operation
- **Window.** `pix_data` is the bottom-right element m33 of the window. m31..m33 is the current line, m21..m23 is the line before it, m11..m13 is two lines up. The window shifts and the line buffers are written only when `pix_de`=1.
- **Counters.**
  - `col` clears on the rising edge of `pix_de` and increments per DE pixel. It saturates at IMG_W.
  - `row` clears on the rising edge of `pix_vsync` and increments on each falling edge of `pix_de`. It saturates at 2.
- **Border.** A window is valid only when col≥2, row≥2 and col<IMG_W. An invalid window forces G=0.
- **Arithmetic**, all unsigned:
  - Gx1 = m11+2·m21+m31, Gx3 = m13+2·m23+m33, Gy1 = m11+2·m12+m13, Gy3 = m31+2·m32+m33. Each is DATA_W+2 bits.
  - Gx = |Gx1−Gx3| and Gy = |Gy1−Gy3|, each DATA_W+2 bits.
  - G = Gx+Gy, DATA_W+3 bits. There is no overflow at any stage.
- **Edge.** edge = (G > thresh) && de_aligned, a strict compare. G == thresh is not an edge.
- **Magnitude.** mag = min(G, 2^DATA_W−1).
- **Mode select:**
  - BINARY: `sobel_data`=0.
  - MAG: `sobel_data`=mag.
  - MAG_THR: `sobel_data`=mag when edge, otherwise 0.
  - `sobel_edge` is valid in all modes.
- **Lines longer than IMG_W.** Extra pixels are not written to the line buffers and produce no edge. The output timing still tracks the input.
- **Mid-operation changes.** A change on `mode` or `thresh` takes effect on the output 1 cycle after it is sampled, at stage 3. No frame alignment is applied.
- **Reset mid-frame.** All pipeline and sync registers and both counters clear. Line-buffer RAM is not cleared; border suppression covers the stale rows. Normal output resumes from the third line after reset.

## Timing
- Fixed latency of 4 cycles, input pixel to output, with no stalls:
  - S0: window register.
  - S1: partial sums.
  - S2: absolute values.
  - S3: G, compare and mode mux, registered.
- Sync outputs are 4-deep shift registers, so `sobel_*` timing equals `pix_*` delayed by exactly 4 cycles.
- Values while `rst`=1:
  - `sobel_vsync`, `sobel_hsync`, `sobel_de` = 0.
  - `sobel_data` = 0.
  - `sobel_edge` = ~EDGE_POL.
- While `sobel_de`=0: `sobel_data`=0 and `sobel_edge`=~EDGE_POL.
- Line buffers use synchronous-read RAM with read-before-write at the same address (`col`). Read data is ready for S0 in the same cycle the pixel is registered.

## Structure
- Package `sobel_pkg` holds:
  - the mode constants MODE_BINARY, MODE_MAG, MODE_MAG_THR;
  - localparam widths SUM_W = DATA_W+2 and G_W = DATA_W+3, expressed as functions of DATA_W;
  - LATENCY = 4.
- Sub-module `sobel_win3x3` contains the two IMG_W×DATA_W line buffers, the col/row counters, the 3×3 shift window and the `win_valid` output.
- The top level contains S1–S3, the sync delay and the output mux.

## Test plan
- **Flat frame.** 8×6 frame, all pixels 100, mode=MAG, thresh=0. Expect `sobel_data`=0 on every DE pixel and `sobel_de` to be `pix_de` delayed by 4.
- **Vertical step.** Columns 0–3 = 0, columns 4–7 = 255, DATA_W=8. At row≥2, col 4: Gx=1020, G=1020.
  - MAG gives `sobel_data`=255.
  - BINARY with thresh=1019 gives edge; thresh=1020 gives no edge.
- **Border.** Any image: rows 0–1 and columns 0–1 of each line always produce G=0 and `sobel_edge`=~EDGE_POL, even when an edge is present there.
- **Threshold mode.** Horizontal ramp with step 10, so Gx=80 and G=80. MAG_THR with thresh=79 gives 80; with thresh=80 gives 0.
- **Overlong line.** IMG_W=8, 12-pixel line. Pixels at col≥8 give no edge. The next line's window data is uncorrupted.
- **Reset mid-frame.** Assert `rst` during row 3. All outputs drop to reset values asynchronously. After release and the next `pix_vsync`, the first two rows are suppressed and the vertical-step result reappears at row 2.
